matrix_row_dispatcher: RTL and testbench

Upstream feeder for the matrix-core socket. Accepts a serial stream of DATA_SIZE-bit matrix elements and packs COLUMN_SIZE elements into one row buffer. Hands each completed row to the next idle core among `Cores` instances, using round-robin order and a load/busy handshake. Tags each row with its index and end-of-matrix status.

---
 rtl/matrix_row_dispatcher.sv | 200 ++++++++++++++++++++
 tb/tb_matrix_row_dispatcher.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_row_dispatcher.sv
// -----------------------------------------------------------------------------
// matrix_row_dispatcher
//
// Upstream feeder for the matrix-core socket. Serial DATA_SIZE-bit elements are
// packed into a COLUMN_SIZE-element row buffer. Each completed row is handed to
// the next idle core (round-robin starting after the last core served) with a
// one-cycle, one-hot load strobe. The row is tagged with its index and with an
// end-of-matrix flag.
//
// Optional build macro: DISPATCH_STATS_EN
//   When defined, adds the 32-bit saturating output stall_cycles. It counts the
//   SEEK cycles in which no core was eligible to take the pending row.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   in_valid       in   element valid
//   in_ready       out  dispatcher can accept an element (decoded from state)
//   in_data        in   element value
//   in_last        in   element is the final element of the matrix
//   core_busy      in   per-core busy, bit k high = core k cannot take a row
//   core_load      out  one-hot, single-cycle load strobe
//   core_row_data  out  packed row, element 0 in the LSBs
//   core_row_idx   out  row index of the row being loaded
//   core_row_last  out  row being loaded is the last row of the matrix
//   matrix_done    out  one-cycle pulse in the cycle after the last row issues
//   stall_cycles   out  (DISPATCH_STATS_EN only) stalled SEEK cycle count
// -----------------------------------------------------------------------------
module matrix_row_dispatcher #(
    parameter int DATA_SIZE   = 16,
    parameter int COLUMN_SIZE = 16,
    parameter int ROW_SIZE    = 16,
    parameter int Cores       = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_SIZE-1:0]             in_data,
    input  logic                             in_last,
    input  logic [Cores-1:0]                 core_busy,
    output logic [Cores-1:0]                 core_load,
    output logic [DATA_SIZE*COLUMN_SIZE-1:0] core_row_data,
    output logic [$clog2(ROW_SIZE)-1:0]      core_row_idx,
    output logic                             core_row_last,
    output logic                             matrix_done
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]                      stall_cycles
`endif
);

    localparam int CW = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
    localparam int RW = $clog2(ROW_SIZE);
    localparam int PW = (Cores > 1) ? $clog2(Cores) : 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SEEK  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        col_cnt_q;
    logic [RW-1:0]        row_cnt_q;
    logic [PW-1:0]        rr_ptr_q;
    logic [Cores-1:0]     pending_q;
    logic                 last_flag_q;
    logic [DATA_SIZE-1:0] row_q [COLUMN_SIZE];
    logic [Cores-1:0]     core_load_q;
    logic [RW-1:0]        core_row_idx_q;
    logic                 core_row_last_q;
    logic                 matrix_done_q;

    logic [Cores-1:0]     eligible_c;
    logic                 found_c;
    logic [PW-1:0]        sel_c;
    logic [PW:0]          scan_c;
    logic [Cores-1:0]     core_load_d;
    logic [PW-1:0]        rr_ptr_d;

    // in_ready is the only combinational output; it is forced low while reset
    // is asserted even though the reset state is FILL.
    assign in_ready      = rst_n & (state_q == FILL);
    assign core_load     = core_load_q;
    assign core_row_idx  = core_row_idx_q;
    assign core_row_last = core_row_last_q;
    assign matrix_done   = matrix_done_q;

    // The row buffer is itself the registered row output; it is only cleared
    // on the exit from ISSUE, so the data is stable while core_load is high.
    for (genvar g = 0; g < COLUMN_SIZE; g++) begin : g_pack
        assign core_row_data[g*DATA_SIZE +: DATA_SIZE] = row_q[g];
    end

    // A core just loaded stays masked for two cycles (ISSUE and the following
    // cycle) so a row is never offered to a core whose busy has not risen yet.
    assign eligible_c = ~core_busy & ~pending_q;

    // Round-robin scan starting at rr_ptr_q, wrapping modulo Cores.
    always_comb begin
        found_c = 1'b0;
        sel_c   = '0;
        scan_c  = '0;
        for (int k = 0; k < Cores; k++) begin
            scan_c = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (scan_c >= (PW+1)'(Cores)) begin
                scan_c = scan_c - (PW+1)'(Cores);
            end
            if (!found_c && eligible_c[scan_c[PW-1:0]]) begin
                found_c = 1'b1;
                sel_c   = scan_c[PW-1:0];
            end
        end
    end

    assign core_load_d = Cores'(1) << sel_c;
    assign rr_ptr_d    = (sel_c == PW'(Cores - 1)) ? '0 : sel_c + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= FILL;
            col_cnt_q       <= '0;
            row_cnt_q       <= '0;
            rr_ptr_q        <= '0;
            pending_q       <= '0;
            last_flag_q     <= 1'b0;
            core_load_q     <= '0;
            core_row_idx_q  <= '0;
            core_row_last_q <= 1'b0;
            matrix_done_q   <= 1'b0;
            for (int i = 0; i < COLUMN_SIZE; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            core_load_q   <= '0;
            matrix_done_q <= 1'b0;
            pending_q     <= core_load_q |
                             ((state_q == SEEK && found_c) ? core_load_d : '0);

            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        row_q[col_cnt_q] <= in_data;
                        col_cnt_q        <= col_cnt_q + 1'b1;
                        if (col_cnt_q == CW'(COLUMN_SIZE - 1) || in_last) begin
                            state_q     <= SEEK;
                            // The final row index forces end-of-matrix.
                            last_flag_q <= in_last | (row_cnt_q == RW'(ROW_SIZE - 1));
                        end
                    end
                end

                SEEK: begin
                    if (found_c) begin
                        core_load_q     <= core_load_d;
                        core_row_idx_q  <= row_cnt_q;
                        core_row_last_q <= last_flag_q;
                        rr_ptr_q        <= rr_ptr_d;
                        state_q         <= ISSUE;
                    end
                end

                ISSUE: begin
                    // Dispatch is committed; core_busy is not consulted here.
                    state_q   <= FILL;
                    col_cnt_q <= '0;
                    for (int i = 0; i < COLUMN_SIZE; i++) begin
                        row_q[i] <= '0;
                    end
                    if (last_flag_q) begin
                        row_cnt_q     <= '0;
                        matrix_done_q <= 1'b1;
                    end else begin
                        row_cnt_q <= row_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [31:0] stall_cycles_q;

    assign stall_cycles = stall_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else if (state_q == SEEK && !found_c && stall_cycles_q != 32'hFFFF_FFFF) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_row_dispatcher.sv
module tb_matrix_row_dispatcher;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic         in_last;
    logic [3:0]   core_busy;
    logic [3:0]   core_load;
    logic [255:0] core_row_data;
    logic [3:0]   core_row_idx;
    logic         core_row_last;
    logic         matrix_done;
`ifdef DISPATCH_STATS_EN
    logic [31:0]  stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    matrix_row_dispatcher #(
        .DATA_SIZE  (16),
        .COLUMN_SIZE(16),
        .ROW_SIZE   (16),
        .Cores      (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .core_busy    (core_busy),
        .core_load    (core_load),
        .core_row_data(core_row_data),
        .core_row_idx (core_row_idx),
        .core_row_last(core_row_last),
        .matrix_done  (matrix_done)
`ifdef DISPATCH_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        core_busy = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_core_load", core_load, 0);
        check("rst_row_data", core_row_data, 0);
        check("rst_row_idx", core_row_idx, 0);
        check("rst_row_last", core_row_last, 0);
        check("rst_done", matrix_done, 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);
    endtask

    task automatic push(input logic [15:0] d, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
    endtask

    // Sends n elements base, base+1, ...; the last one carries in_last when
    // use_last is set. Checks the issued row against a locally built model.
    task automatic do_row(input string tag, input int n, input logic [15:0] base,
                          input logic use_last, input logic [3:0] exp_load,
                          input logic [3:0] exp_idx, input logic exp_last);
        logic [255:0] exp_row;
        logic [15:0]  v;
        int lat;
        exp_row = '0;
        for (int j = 0; j < n; j++) begin
            v = base + 16'(j);
            exp_row[j*16 +: 16] = v;
            push(v, use_last && (j == n - 1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        lat = 1;
        while (core_load == 4'b0000 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 2);
        check({tag, "_load"}, core_load, exp_load);
        check({tag, "_idx"}, core_row_idx, exp_idx);
        check({tag, "_last"}, core_row_last, exp_last);
        check({tag, "_data"}, core_row_data, exp_row);
        check({tag, "_ready_issue"}, in_ready, 0);
        check({tag, "_done_issue"}, matrix_done, 0);
        @(negedge clk);
        check({tag, "_load_gone"}, core_load, 0);
        check({tag, "_done"}, matrix_done, exp_last);
        check({tag, "_ready_fill"}, in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        core_busy = '0;

        // Basic row plus round-robin over five rows.
        apply_reset();
        do_row("row0", 16, 16'h0001, 1'b0, 4'b0001, 4'd0, 1'b0);
        do_row("row1", 16, 16'h0101, 1'b0, 4'b0010, 4'd1, 1'b0);
        do_row("row2", 16, 16'h0201, 1'b0, 4'b0100, 4'd2, 1'b0);
        do_row("row3", 16, 16'h0301, 1'b0, 4'b1000, 4'd3, 1'b0);
        do_row("row4", 16, 16'h0401, 1'b0, 4'b0001, 4'd4, 1'b0);

        // All cores busy: hold in SEEK for ten cycles, then free core 2 only.
        apply_reset();
        core_busy = 4'b1111;
        for (int j = 0; j < 16; j++) push(16'h1000 + 16'(j), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("stall_ready0", in_ready, 0);
        repeat (10) @(negedge clk);
        check("stall_noload", core_load, 0);
        check("stall_ready", in_ready, 0);
`ifdef DISPATCH_STATS_EN
        check("stall_count", stall_cycles, 10);
`endif
        core_busy = 4'b1011;
        @(negedge clk);
        check("stall_load", core_load, 4'b0100);
        check("stall_idx", core_row_idx, 0);
        check("stall_last", core_row_last, 0);
        check("stall_lsb", core_row_data[15:0], 16'h1000);
        check("stall_msb", core_row_data[255:240], 16'h100F);
`ifdef DISPATCH_STATS_EN
        check("stall_count_hold", stall_cycles, 10);
`endif
        core_busy = 4'b0000;
        @(negedge clk);

        // Partial row ended by in_last, then a one-element row.
        do_row("partial", 5, 16'h2001, 1'b1, 4'b1000, 4'd1, 1'b1);
        do_row("single", 1, 16'h3001, 1'b1, 4'b0001, 4'd0, 1'b1);

        // Sixteen full rows: the row index wraps and row 15 is forced last.
        apply_reset();
        for (int r = 0; r < 17; r++) begin
            do_row($sformatf("wrap%0d", r), 16, 16'(r * 256), 1'b0,
                   4'(1 << (r % 4)), 4'(r % 16), (r == 15));
        end

        // Reset in the middle of a row discards it.
        apply_reset();
        for (int j = 0; j < 7; j++) push(16'h5000 + 16'(j), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_ready", in_ready, 0);
        check("midrst_load", core_load, 0);
        check("midrst_data", core_row_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_noload", core_load, 0);
        end
        do_row("fresh", 16, 16'hA000, 1'b0, 4'b0001, 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
